hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_muldiv_if.sv | 16 +
 rtl/hilo_muldiv_core.sv | 68 ++++++
 rtl/hilo_muldiv.sv | 131 +++++++++++++
 tb/tb_hilo_muldiv.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings for the Hi/Lo multiply-divide unit.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Core-side request/result bundle of the Hi/Lo unit; the core drives start/op/a/b and reads hi/lo/busy/done.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
    import hilo_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (output start, op, a, b, input hi, lo, busy, done);
    modport slave  (input start, op, a, b, output hi, lo, busy, done);
endinterface

// File: rtl/hilo_muldiv_core.sv
// Iterative radix-2 datapath: unsigned shift-add multiply or restoring divide on operand magnitudes.
// Latency: WIDTH step cycles after load; one step per cycle while step is high.
// Backpressure: none; the controlling FSM only steps while it owns the unit.
module hilo_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             last_step,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    // acc_hi: partial product / partial remainder; acc_lo: multiplier / quotient bits.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             mode_div;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic             div_ok;

    always_comb begin
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd};
        div_ok    = ~div_trial[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            mode_div <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= is_div ? opnd_a : opnd_b;
            opnd     <= is_div ? opnd_b : opnd_a;
            mode_div <= is_div;
            cnt      <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (mode_div) begin
                acc_hi <= div_ok ? div_trial[WIDTH:0] : div_shift;
                acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
                acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign res_hi    = acc_hi[WIDTH-1:0];
    assign res_lo    = acc_lo;

endmodule

// File: rtl/hilo_muldiv.sv
// Hi/Lo register pair with iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO moves.
// Latency: arithmetic result and done pulse WIDTH+2 edges after start is accepted; moves take one edge.
// Backpressure: busy high while an arithmetic op runs; any start seen while busy is dropped.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);
    state_t           state, next_state;
    logic             load, step, wr_res, mv_hi, mv_lo;
    logic             last_step;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             is_signed, is_div_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg_q, neg_r, div_q, dz_q;

    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        a_neg     = is_signed & bus.a[WIDTH-1];
        b_neg     = is_signed & bus.b[WIDTH-1];
        mag_a     = a_neg ? -bus.a : bus.a;
        mag_b     = b_neg ? -bus.b : bus.b;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        wr_res     = 1'b0;
        mv_hi      = 1'b0;
        mv_lo      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: mv_hi = 1'b1;
                        OP_MTLO: mv_lo = 1'b1;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load       = 1'b1;
                            next_state = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last_step) next_state = ST_FIN;
            end
            ST_FIN: begin
                wr_res     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    hilo_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .is_div    (is_div_op),
        .opnd_a    (mag_a),
        .opnd_b    (mag_b),
        .last_step (last_step),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // Quotient/product take the xor of operand signs; the remainder follows the dividend.
    always_comb begin
        prod     = {res_hi, res_lo};
        prod_fix = neg_q ? -prod : prod;
        if (div_q) begin
            fix_hi = neg_r ? -res_hi : res_hi;
            fix_lo = dz_q ? '1 : (neg_q ? -res_lo : res_lo);
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= wr_res;
            if (load) begin
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                div_q <= is_div_op;
                dz_q  <= is_div_op && (bus.b == '0);
            end
            if (mv_hi) hi_q <= bus.a;
            if (mv_lo) lo_q <= bus.a;
            if (wr_res) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv at WIDTH = 32 with hand-computed Hi/Lo results.
module tb_hilo_muldiv;
    import hilo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(32)) bus ();

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one arithmetic op and wait until busy drops; cyc counts sampled busy cycles.
    task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            tick();
        end
    endtask

    task automatic arith(input string tag, input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        run_op(op, a, b, cyc);
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        tick();
        chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int cyc;
        int done_seen;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);

        // Moves
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'd1;
        tick();
        chk("mthi_hi", 64'(bus.hi), 64'd1);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_done", 64'(bus.done), 64'd0);
        bus.op = OP_MTLO;
        bus.a  = 32'd3;
        tick();
        bus.start = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'd3);
        chk("mtlo_hi", 64'(bus.hi), 64'd1);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);
        chk("mtlo_done", 64'(bus.done), 64'd0);

        arith("multu_5x6",  OP_MULTU, 32'd5,          32'd6,          32'h0000_0000, 32'd30);
        arith("mult_m3x7",  OP_MULT,  32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB);
        arith("mult_m1xm1", OP_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001);
        arith("multu_big",  OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
        arith("div_m7d2",   OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        arith("div_7dm2",   OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD);
        arith("div_ovf",    OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000);
        arith("divu_100d7", OP_DIVU,  32'd100,        32'd7,          32'd2,         32'd14);
        arith("div_m5d0",   OP_DIV,   32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF);
        arith("divu_9d0",   OP_DIVU,  32'd9,          32'd0,          32'd9,         32'hFFFF_FFFF);

        // MTHI while busy must be dropped; the product high word lands later.
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'h0001_0000;
        bus.b     = 32'h0003_0000;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'hDEAD_BEEF;
        tick();
        bus.start = 1'b0;
        chk("busy_mthi_hi_held", 64'(bus.hi), 64'd9);
        chk("busy_mthi_busy", 64'(bus.busy), 64'd1);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            tick();
        end
        chk("busy_mthi_done", 64'(bus.done), 64'd1);
        chk("busy_mthi_prod_hi", 64'(bus.hi), 64'd3);
        chk("busy_mthi_prod_lo", 64'(bus.lo), 64'd0);
        tick();

        // Abort a MULTU with reset part way through.
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("abort_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        done_seen = 0;
        repeat (40) begin
            if (bus.done) done_seen++;
            if (bus.busy) done_seen++;
            tick();
        end
        chk("abort_no_done_or_busy", 64'(done_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
